// File: rtl/gdm_arbiter.sv
// Single-port GDM arbiter between the Fetch (read-only) and Memory (read/write) stages.
// Each access runs IDLE -> ACCESS (LATENCY cycles) -> RESP (1 cycle) -> IDLE.
module gdm_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LATENCY    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_arb_en,
  input  logic [ADDR_W-1:0] if_arb_addr,
  input  logic              if_arb_flush,
  output logic [DATA_W-1:0] arb_if_data,
  output logic              arb_if_ready,
  output logic              arb_if_stall,
  input  logic              mem_arb_en,
  input  logic              mem_arb_we,
  input  logic [ADDR_W-1:0] mem_arb_addr,
  input  logic [DATA_W-1:0] mem_arb_wdata,
  output logic [DATA_W-1:0] arb_mem_data,
  output logic              arb_mem_ready,
  output logic              arb_mem_stall,
  output logic              arb_gdm_en,
  output logic              arb_gdm_we,
  output logic [ADDR_W-1:0] arb_gdm_addr,
  output logic [DATA_W-1:0] arb_gdm_wdata,
  input  logic [DATA_W-1:0] gdm_arb_data
);

  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int SW    = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(LATENCY - 1);
  localparam logic [SW-1:0]    STARVE_LIM = SW'(STARVE_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              owner_mem_q, owner_mem_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SW-1:0]     starve_q, starve_d;
  logic              flush_q, flush_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [DATA_W-1:0] if_data_q, if_data_d;
  logic [DATA_W-1:0] mem_data_q, mem_data_d;
  logic              if_ready_s, mem_ready_s, in_access_s;

  // A flush seen in the RESP cycle itself must still suppress the pulse, hence the live term.
  assign in_access_s = (state_q == S_ACCESS);
  assign if_ready_s  = (state_q == S_RESP) & ~owner_mem_q & ~flush_q & ~if_arb_flush;
  assign mem_ready_s = (state_q == S_RESP) & owner_mem_q;

  assign arb_gdm_en    = in_access_s;
  assign arb_gdm_we    = in_access_s & we_q;
  assign arb_gdm_addr  = in_access_s ? addr_q  : {ADDR_W{1'b0}};
  assign arb_gdm_wdata = in_access_s ? wdata_q : {DATA_W{1'b0}};
  assign arb_if_ready  = if_ready_s;
  assign arb_mem_ready = mem_ready_s;
  assign arb_if_data   = if_ready_s ? rdata_q : if_data_q;
  assign arb_mem_data  = (mem_ready_s & ~we_q) ? rdata_q : mem_data_q;
  assign arb_if_stall  = reset & if_arb_en & ~if_ready_s;
  assign arb_mem_stall = reset & mem_arb_en & ~mem_ready_s;

  // Next-state: arbitration in IDLE, latency count in ACCESS, result commit in RESP.
  always_comb begin
    state_d     = state_q;
    owner_mem_d = owner_mem_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    flush_d     = flush_q;
    rdata_d     = rdata_q;
    if_data_d   = if_data_q;
    mem_data_d  = mem_data_q;
    case (state_q)
      S_IDLE: begin
        if (mem_arb_en && (!if_arb_en || (starve_q < STARVE_LIM))) begin
          state_d     = S_ACCESS;
          owner_mem_d = 1'b1;
          we_d        = mem_arb_we;
          addr_d      = mem_arb_addr;
          wdata_d     = mem_arb_wdata;
          cnt_d       = CNT_INIT;
          flush_d     = 1'b0;
          if (if_arb_en && (starve_q != STARVE_LIM)) begin
            starve_d = starve_q + {{(SW-1){1'b0}}, 1'b1};
          end else begin
            starve_d = starve_q;
          end
        end else if (if_arb_en) begin
          state_d     = S_ACCESS;
          owner_mem_d = 1'b0;
          we_d        = 1'b0;
          addr_d      = if_arb_addr;
          wdata_d     = {DATA_W{1'b0}};
          cnt_d       = CNT_INIT;
          flush_d     = 1'b0;
          starve_d    = {SW{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACCESS: begin
        flush_d = flush_q | (~owner_mem_q & if_arb_flush);
        if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = S_RESP;
          rdata_d = gdm_arb_data;
        end else begin
          cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (if_ready_s) begin
          if_data_d = rdata_q;
        end else begin
          if_data_d = if_data_q;
        end
        if (mem_ready_s && !we_q) begin
          mem_data_d = rdata_q;
        end else begin
          mem_data_d = mem_data_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      owner_mem_q <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= {ADDR_W{1'b0}};
      wdata_q     <= {DATA_W{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      starve_q    <= {SW{1'b0}};
      flush_q     <= 1'b0;
      rdata_q     <= {DATA_W{1'b0}};
      if_data_q   <= {DATA_W{1'b0}};
      mem_data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q     <= state_d;
      owner_mem_q <= owner_mem_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      flush_q     <= flush_d;
      rdata_q     <= rdata_d;
      if_data_q   <= if_data_d;
      mem_data_q  <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_gdm_arbiter.sv
// Directed testbench for gdm_arbiter (LATENCY=2, STARVE_MAX=3).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_gdm_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        if_arb_en = 1'b0;
  logic [31:0] if_arb_addr = 32'h0;
  logic        if_arb_flush = 1'b0;
  logic [31:0] arb_if_data;
  logic        arb_if_ready;
  logic        arb_if_stall;
  logic        mem_arb_en = 1'b0;
  logic        mem_arb_we = 1'b0;
  logic [31:0] mem_arb_addr = 32'h0;
  logic [31:0] mem_arb_wdata = 32'h0;
  logic [31:0] arb_mem_data;
  logic        arb_mem_ready;
  logic        arb_mem_stall;
  logic        arb_gdm_en;
  logic        arb_gdm_we;
  logic [31:0] arb_gdm_addr;
  logic [31:0] arb_gdm_wdata;
  logic [31:0] gdm_arb_data = 32'h0;

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_if_data = 32'h0;
  logic [31:0] exp_mem_data = 32'h0;

  gdm_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(2), .STARVE_MAX(3)) dut (
    .clock(clock), .reset(reset),
    .if_arb_en(if_arb_en), .if_arb_addr(if_arb_addr), .if_arb_flush(if_arb_flush),
    .arb_if_data(arb_if_data), .arb_if_ready(arb_if_ready), .arb_if_stall(arb_if_stall),
    .mem_arb_en(mem_arb_en), .mem_arb_we(mem_arb_we), .mem_arb_addr(mem_arb_addr),
    .mem_arb_wdata(mem_arb_wdata), .arb_mem_data(arb_mem_data),
    .arb_mem_ready(arb_mem_ready), .arb_mem_stall(arb_mem_stall),
    .arb_gdm_en(arb_gdm_en), .arb_gdm_we(arb_gdm_we), .arb_gdm_addr(arb_gdm_addr),
    .arb_gdm_wdata(arb_gdm_wdata), .gdm_arb_data(gdm_arb_data)
  );

  always #5 clock = ~clock;

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_gdm_wdata, arb_if_ready, arb_mem_ready,
         arb_if_stall, arb_mem_stall, arb_if_data, arb_mem_data} !== 134'h0) begin
      failures++;
      $display("FAIL reset_outputs got en=%0b we=%0b addr=%h ifrdy=%0b memrdy=%0b ifd=%h memd=%h exp all 0",
               arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_if_ready, arb_mem_ready, arb_if_data, arb_mem_data);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_if_alone();
    cyc();
    if_arb_en = 1'b1; if_arb_addr = 32'h40; gdm_arb_data = 32'h0000000B;
    #1;
    checks++;
    if ({arb_if_stall, arb_gdm_en} !== 2'b10) begin
      failures++; $display("FAIL t1_c0 stall/en got %b exp 10", {arb_if_stall, arb_gdm_en});
    end
    for (int c = 1; c <= 2; c++) begin
      cyc();
      checks++;
      if ({arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_if_stall, arb_if_ready} !== {1'b1, 1'b0, 32'h40, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL t1_access c%0d got en=%0b we=%0b addr=%h stall=%0b rdy=%0b exp 1 0 40 1 0",
                 c, arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_if_stall, arb_if_ready);
      end
    end
    cyc();
    exp_if_data = 32'h0000000B;
    checks++;
    if ({arb_if_ready, arb_if_data, arb_if_stall, arb_gdm_en} !== {1'b1, exp_if_data, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL t1_resp got rdy=%0b data=%h stall=%0b en=%0b exp 1 %h 0 0",
               arb_if_ready, arb_if_data, arb_if_stall, arb_gdm_en, exp_if_data);
    end
    if_arb_en = 1'b0;
    cyc();
    checks++;
    if ({arb_if_ready, arb_if_data} !== {1'b0, exp_if_data}) begin
      failures++; $display("FAIL t1_after got rdy=%0b data=%h exp 0 %h", arb_if_ready, arb_if_data, exp_if_data);
    end
  endtask

  task automatic test_simultaneous();
    cyc();
    if_arb_en = 1'b1; if_arb_addr = 32'h40;
    mem_arb_en = 1'b1; mem_arb_we = 1'b0; mem_arb_addr = 32'h80; gdm_arb_data = 32'h22;
    for (int c = 1; c <= 2; c++) begin
      cyc();
      checks++;
      if ({arb_gdm_en, arb_gdm_addr, arb_if_stall, arb_mem_stall} !== {1'b1, 32'h80, 1'b1, 1'b1}) begin
        failures++;
        $display("FAIL t2_mem_access c%0d got en=%0b addr=%h exp 1 80", c, arb_gdm_en, arb_gdm_addr);
      end
    end
    cyc();
    exp_mem_data = 32'h22;
    checks++;
    if ({arb_mem_ready, arb_mem_data, arb_if_ready, arb_if_stall} !== {1'b1, exp_mem_data, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL t2_mem_resp got memrdy=%0b memd=%h ifrdy=%0b ifstall=%0b exp 1 %h 0 1",
               arb_mem_ready, arb_mem_data, arb_if_ready, arb_if_stall, exp_mem_data);
    end
    mem_arb_en = 1'b0;
    cyc();
    gdm_arb_data = 32'h33;
    checks++;
    if (arb_gdm_en !== 1'b0) begin
      failures++; $display("FAIL t2_idle got en=%0b exp 0", arb_gdm_en);
    end
    for (int c = 5; c <= 6; c++) begin
      cyc();
      checks++;
      if ({arb_gdm_en, arb_gdm_addr} !== {1'b1, 32'h40}) begin
        failures++; $display("FAIL t2_if_access c%0d got en=%0b addr=%h exp 1 40", c, arb_gdm_en, arb_gdm_addr);
      end
    end
    cyc();
    exp_if_data = 32'h33;
    checks++;
    if ({arb_if_ready, arb_if_data, arb_mem_data} !== {1'b1, exp_if_data, exp_mem_data}) begin
      failures++;
      $display("FAIL t2_if_resp got rdy=%0b ifd=%h memd=%h exp 1 %h %h",
               arb_if_ready, arb_if_data, arb_mem_data, exp_if_data, exp_mem_data);
    end
    if_arb_en = 1'b0;
  endtask

  task automatic test_mem_write();
    cyc();
    mem_arb_en = 1'b1; mem_arb_we = 1'b1; mem_arb_addr = 32'h100; mem_arb_wdata = 32'hDEADBEEF;
    gdm_arb_data = 32'h55;
    for (int c = 1; c <= 2; c++) begin
      cyc();
      checks++;
      if ({arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_gdm_wdata} !== {1'b1, 1'b1, 32'h100, 32'hDEADBEEF}) begin
        failures++;
        $display("FAIL t3_write c%0d got en=%0b we=%0b addr=%h wdata=%h exp 1 1 100 deadbeef",
                 c, arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_gdm_wdata);
      end
    end
    cyc();
    checks++;
    if ({arb_mem_ready, arb_mem_data, arb_gdm_we} !== {1'b1, exp_mem_data, 1'b0}) begin
      failures++;
      $display("FAIL t3_resp got rdy=%0b memd=%h we=%0b exp 1 %h 0", arb_mem_ready, arb_mem_data, arb_gdm_we, exp_mem_data);
    end
    mem_arb_en = 1'b0; mem_arb_we = 1'b0;
  endtask

  task automatic test_starvation();
    logic exp_mem;
    cyc();
    if_arb_en = 1'b1; if_arb_addr = 32'h40;
    mem_arb_en = 1'b1; mem_arb_we = 1'b0; mem_arb_addr = 32'h80; gdm_arb_data = 32'h44;
    for (int k = 0; k < 5; k++) begin
      exp_mem = (k != 3);
      cyc();
      checks++;
      if (arb_gdm_addr !== (exp_mem ? 32'h80 : 32'h40)) begin
        failures++; $display("FAIL t4_grant k%0d got addr=%h exp %h", k, arb_gdm_addr, exp_mem ? 32'h80 : 32'h40);
      end
      cyc();
      cyc();
      checks++;
      if ({arb_mem_ready, arb_if_ready} !== {exp_mem, ~exp_mem}) begin
        failures++;
        $display("FAIL t4_resp k%0d got memrdy=%0b ifrdy=%0b exp %0b %0b", k, arb_mem_ready, arb_if_ready, exp_mem, ~exp_mem);
      end
      if (k == 4) begin
        if_arb_en = 1'b0; mem_arb_en = 1'b0;
      end
      if (k < 4) cyc();
    end
    exp_if_data = 32'h44;
    exp_mem_data = 32'h44;
  endtask

  task automatic test_flush();
    cyc();
    if_arb_en = 1'b1; if_arb_addr = 32'h40; gdm_arb_data = 32'h77;
    cyc();
    checks++;
    if (arb_gdm_en !== 1'b1) begin
      failures++; $display("FAIL t5_c1 got en=%0b exp 1", arb_gdm_en);
    end
    cyc();
    if_arb_flush = 1'b1;
    #1;
    checks++;
    if ({arb_gdm_en, arb_gdm_addr} !== {1'b1, 32'h40}) begin
      failures++; $display("FAIL t5_c2 got en=%0b addr=%h exp 1 40", arb_gdm_en, arb_gdm_addr);
    end
    cyc();
    if_arb_flush = 1'b0;
    #1;
    checks++;
    if ({arb_if_ready, arb_if_data, arb_gdm_en} !== {1'b0, exp_if_data, 1'b0}) begin
      failures++;
      $display("FAIL t5_dropped got rdy=%0b data=%h en=%0b exp 0 %h 0", arb_if_ready, arb_if_data, arb_gdm_en, exp_if_data);
    end
    if_arb_en = 1'b0;
    cyc();
    if_arb_en = 1'b1; if_arb_addr = 32'h80; gdm_arb_data = 32'h99;
    for (int c = 5; c <= 6; c++) begin
      cyc();
      checks++;
      if ({arb_gdm_en, arb_gdm_addr} !== {1'b1, 32'h80}) begin
        failures++; $display("FAIL t5_next c%0d got en=%0b addr=%h exp 1 80", c, arb_gdm_en, arb_gdm_addr);
      end
    end
    cyc();
    exp_if_data = 32'h99;
    checks++;
    if ({arb_if_ready, arb_if_data} !== {1'b1, exp_if_data}) begin
      failures++; $display("FAIL t5_next_resp got rdy=%0b data=%h exp 1 %h", arb_if_ready, arb_if_data, exp_if_data);
    end
    if_arb_en = 1'b0;
  endtask

  task automatic test_async_reset();
    cyc();
    mem_arb_en = 1'b1; mem_arb_we = 1'b0; mem_arb_addr = 32'h200; gdm_arb_data = 32'h66;
    cyc();
    checks++;
    if (arb_gdm_en !== 1'b1) begin
      failures++; $display("FAIL t6_pre got en=%0b exp 1", arb_gdm_en);
    end
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if ({arb_gdm_en, arb_gdm_we, arb_gdm_addr, arb_mem_stall, arb_mem_ready, arb_mem_data, arb_if_data} !== 100'h0) begin
      failures++;
      $display("FAIL t6_reset got en=%0b addr=%h stall=%0b rdy=%0b memd=%h ifd=%h exp all 0",
               arb_gdm_en, arb_gdm_addr, arb_mem_stall, arb_mem_ready, arb_mem_data, arb_if_data);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++;
    if ({arb_gdm_en, arb_mem_stall} !== 2'b01) begin
      failures++; $display("FAIL t6_idle got en=%0b stall=%0b exp 0 1", arb_gdm_en, arb_mem_stall);
    end
    for (int c = 1; c <= 2; c++) begin
      cyc();
      checks++;
      if ({arb_gdm_en, arb_gdm_addr} !== {1'b1, 32'h200}) begin
        failures++; $display("FAIL t6_access c%0d got en=%0b addr=%h exp 1 200", c, arb_gdm_en, arb_gdm_addr);
      end
    end
    cyc();
    checks++;
    if ({arb_mem_ready, arb_mem_data} !== {1'b1, 32'h66}) begin
      failures++; $display("FAIL t6_resp got rdy=%0b memd=%h exp 1 66", arb_mem_ready, arb_mem_data);
    end
    mem_arb_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_if_alone();
    test_simultaneous();
    test_mem_write();
    test_starvation();
    test_flush();
    test_async_reset();
    cyc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
